load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-stage executor for the RV32I pipeline.
- Consumes the decoded memory controls (memwrite, memarea, memsel, funct3) plus the ALU address and store data.
- Drives a word-wide data-memory request/acknowledge bus, applies byte-lane alignment and load sign/zero extension, and returns the writeback value selected by memsel.
- Stalls the pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for mem_ack before aborting with an error (≥1).
- XLEN, 32: data/address width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  stage input valid
- in_ready  out  1  unit can accept an op (state IDLE)
- memwrite  in  1  1 = store
- memarea  in  2  0 byte, 1 half, 2 word, 3 illegal
- memsel  in  2  writeback source: 0 pc+4, 1 memory, 2 alu
- funct3  in  3  load/store funct3; bit 2 = unsigned load
- alu_res  in  32  effective address / ALU result
- store_data  in  32  rs2 value
- pc4  in  32  pc+4 for jal/jalr
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address ({alu_res[31:2],2'b00})
- mem_wstrb  out  4  byte write strobes
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  access complete
- out_valid  out  1  one-cycle pulse: result ready for writeback
- out_data  out  32  writeback value
- out_err  out  1  qualifies out_valid: misaligned, illegal memarea, or timeout

Behaviour:
- Reset (also mid-access): state IDLE; mem_req, mem_we, mem_wstrb, out_valid, out_err = 0; out_data, mem_addr, mem_wdata = 0. A late mem_ack arriving in IDLE is ignored.
- States: IDLE, ACCESS, DONE.
- IDLE: in_ready = 1. On in_valid:
  - Access op (memwrite = 1 or memsel = 1), aligned, and memarea ≠ 3: latch controls, register the mem_* outputs, go to ACCESS.
  - Access op that is misaligned or has memarea = 3: go to DONE with err = 1 and out_data = 0. No memory request is made.
  - Otherwise (no access): out_data = pc4 if memsel = 0, else alu_res; go to DONE. This gives 1-cycle latency.
- Alignment rules: half requires alu_res[0] = 0; word requires alu_res[1:0] = 0.
- ACCESS: mem_req = 1, and mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata are held stable until ack. A cycle counter starts at 0.
  - On mem_ack: a load captures the extracted rdata into out_data; a store sets out_data = 0. Go to DONE. mem_req drops on the next edge.
  - If the counter reaches TIMEOUT-1 without ack: drop mem_req, set err = 1, go to DONE.
  - Ack on the final timeout cycle counts as success.
- DONE: out_valid = 1 for exactly one cycle, out_err = err. Return to IDLE. in_ready = 0 in ACCESS and DONE.
- Minimum load/store latency: accept → ACCESS (req asserted) → ack at the earliest in the same cycle → DONE. That is 2 cycles from accept to out_valid with zero-wait memory.
- Store lanes:
  - byte: wstrb = 4'b0001 << addr[1:0], wdata = {4{sd[7:0]}}
  - half: wstrb = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{sd[15:0]}}
  - word: wstrb = 4'b1111, wdata = sd
- Loads: mem_we = 0, wstrb = 0. The byte or half is selected by addr[1:0] and sign-extended unless funct3[2] = 1, in which case it is zero-extended.
- A store with memsel = 1 is treated as a store.

Decomposition:
- Shared package lsu_pkg: memarea encodings (AREA_B/H/W), memsel encodings (SEL_PC4/MEM/ALU), funct3 load codes (LB, LH, LW, LBU, LHU), state enum.
- One combinational sub-module, lsu_lane_align: store strobe/data generation and load extraction/extension, with a misalign flag output.

Test Plan:
- sw: alu_res = 0x100, sd = 0xDEADBEEF, ack on the first ACCESS cycle → mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF, out_valid 2 cycles after accept, out_err 0.
- sb: alu_res = 0x103, sd = 0x000000A5 → wstrb 1000, wdata 0xA5A5A5A5.
- lb vs lbu: alu_res = 0x202, rdata = 0x12F4_5678, after 3 wait cycles → out_data 0xFFFFFFF4 (lb) and 0x000000F4 (lbu); in_ready low throughout.
- lh at 0x201 → no mem_req, out_valid with out_err = 1, out_data = 0. lw at 0x202 → same result.
- jal (memsel 0, pc4 = 0x84) → out_data 0x84 one cycle later. ALU op (memsel 2, alu_res 7) → out_data 7.
- Timeout: no ack → mem_req high exactly 16 cycles, then out_err = 1. Separately, assert rst during ACCESS → mem_req 0 after that edge; a subsequent ack is ignored and produces no out_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the RV32I memory-stage load/store unit.
// Memory area and writeback-select codes, load funct3 values and the FSM state type.
package lsu_pkg;

    localparam logic [1:0] AREA_B   = 2'd0;
    localparam logic [1:0] AREA_H   = 2'd1;
    localparam logic [1:0] AREA_W   = 2'd2;
    localparam logic [1:0] AREA_BAD = 2'd3;

    localparam logic [1:0] SEL_PC4 = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_ALU = 2'd2;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit.
// The store side is evaluated at accept time; the load side uses the controls latched for the access.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_area,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    output logic        misalign,
    input  logic [1:0]  ld_area,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [15:0] ld_lo;

    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = st_data;
        case (st_area)
            AREA_B: begin
                st_wstrb = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            AREA_H: begin
                st_wstrb = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            AREA_W: st_wstrb = 4'b1111;
            default: ;
        endcase
    end

    assign misalign = ((st_area == AREA_H) && st_off[0]) ||
                      ((st_area == AREA_W) && (st_off != 2'b00));

    // Shift the addressed byte/half down to bit 0 before extending.
    assign ld_lo = 16'(ld_rdata >> {ld_off, 3'b000});

    always_comb begin
        ld_data = ld_rdata;
        case (ld_area)
            AREA_B: ld_data = ld_unsigned ? {24'b0, ld_lo[7:0]}
                                          : {{24{ld_lo[7]}}, ld_lo[7:0]};
            AREA_H: ld_data = ld_unsigned ? {16'b0, ld_lo}
                                          : {{16{ld_lo[15]}}, ld_lo};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage executor: issues one request/ack data-memory access per op and
// returns the aligned, extended writeback value; non-memory ops pass through in one cycle.
//
// state     | meaning
// ST_IDLE   | ready for a new op
// ST_ACCESS | request outstanding, counting wait cycles
// ST_DONE   | out_valid pulse with result / error
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            memwrite,
    input  logic [1:0]      memarea,
    input  logic [1:0]      memsel,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_res,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] pc4,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic            out_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [3:0]      mem_wstrb_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_data_q;
    logic            out_err_q;
    logic [1:0]      ld_area_q;
    logic [1:0]      ld_off_q;
    logic            ld_uns_q;

    logic            access_d;
    logic            bad_d;
    logic            misalign_d;
    logic [3:0]      st_wstrb_d;
    logic [31:0]     st_wdata_d;
    logic [31:0]     ld_data_d;

    // Only the signedness bit of funct3 matters; size comes from memarea.
    logic [1:0] unused_funct3;
    assign unused_funct3 = funct3[1:0];

    lsu_lane_align u_align (
        .st_area     (memarea),
        .st_off      (alu_res[1:0]),
        .st_data     (store_data),
        .st_wstrb    (st_wstrb_d),
        .st_wdata    (st_wdata_d),
        .misalign    (misalign_d),
        .ld_area     (ld_area_q),
        .ld_off      (ld_off_q),
        .ld_unsigned (ld_uns_q),
        .ld_rdata    (mem_rdata),
        .ld_data     (ld_data_d)
    );

    assign access_d = memwrite || (memsel == SEL_MEM);
    assign bad_d    = misalign_d || (memarea == AREA_BAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            ld_area_q   <= AREA_B;
            ld_off_q    <= 2'b00;
            ld_uns_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (access_d && bad_d) begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                            out_data_q  <= '0;
                        end else if (access_d) begin
                            state_q     <= ST_ACCESS;
                            cnt_q       <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= memwrite;
                            mem_addr_q  <= {alu_res[XLEN-1:2], 2'b00};
                            mem_wstrb_q <= memwrite ? st_wstrb_d : 4'b0000;
                            mem_wdata_q <= memwrite ? st_wdata_d : '0;
                            ld_area_q   <= memarea;
                            ld_off_q    <= alu_res[1:0];
                            ld_uns_q    <= funct3[2];
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= (memsel == SEL_PC4) ? pc4 : alu_res;
                        end
                    end
                end
                ST_ACCESS: begin
                    // An ack on the last counted cycle still wins over the timeout.
                    if (mem_ack || (cnt_q == CNT_LAST)) begin
                        state_q     <= ST_DONE;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0000;
                        out_valid_q <= 1'b1;
                        out_err_q   <= !mem_ack;
                        out_data_q  <= (mem_ack && !mem_we_q) ? ld_data_d : '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads with extension, pass-through,
// misaligned/illegal ops, timeout boundary and reset during an access.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        memwrite;
    logic [1:0]  memarea;
    logic [1:0]  memsel;
    logic [2:0]  funct3;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [31:0] pc4;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .memwrite(memwrite), .memarea(memarea), .memsel(memsel), .funct3(funct3),
        .alu_res(alu_res), .store_data(store_data), .pc4(pc4),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_data(out_data), .out_err(out_err)
    );

    // Present one op for a single accept edge; returns 1ns after that edge.
    task automatic drive_op(input logic we, input logic [1:0] area, input logic [1:0] sel,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [31:0] p4);
        memwrite   = we;
        memarea    = area;
        memsel     = sel;
        funct3     = f3;
        alu_res    = addr;
        store_data = sd;
        pc4        = p4;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin errors++; $display("FAIL reset_out: valid %b err %b expected 0 0", out_valid, out_err); end
        checks++; if (out_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_regs: data %h addr %h wdata %h wstrb %b we %b expected all 0", out_data, mem_addr, mem_wdata, mem_wstrb, mem_we); end
        rst = 1'b0;
    endtask

    task automatic test_stores();
        logic [1:0]  areas [4] = '{AREA_W, AREA_B, AREA_H, AREA_W};
        logic [1:0]  sels  [4] = '{SEL_ALU, SEL_ALU, SEL_ALU, SEL_MEM};
        logic [31:0] addrs [4] = '{32'h100, 32'h103, 32'h102, 32'h300};
        logic [31:0] sds   [4] = '{32'hDEADBEEF, 32'h000000A5, 32'h1234BEEF, 32'h00000011};
        logic [31:0] e_addr[4] = '{32'h100, 32'h100, 32'h100, 32'h300};
        logic [3:0]  e_strb[4] = '{4'b1111, 4'b1000, 4'b1100, 4'b1111};
        logic [31:0] e_wd  [4] = '{32'hDEADBEEF, 32'hA5A5A5A5, 32'hBEEFBEEF, 32'h00000011};
        for (int i = 0; i < 4; i++) begin
            drive_op(1'b1, areas[i], sels[i], 3'b010, addrs[i], sds[i], 32'h0);
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL store%0d_req: req %b we %b ready %b expected 1 1 0", i, mem_req, mem_we, in_ready); end
            checks++; if (mem_addr !== e_addr[i]) begin errors++; $display("FAIL store%0d_addr: got %h expected %h", i, mem_addr, e_addr[i]); end
            checks++; if (mem_wstrb !== e_strb[i]) begin errors++; $display("FAIL store%0d_wstrb: got %b expected %b", i, mem_wstrb, e_strb[i]); end
            checks++; if (mem_wdata !== e_wd[i]) begin errors++; $display("FAIL store%0d_wdata: got %h expected %h", i, mem_wdata, e_wd[i]); end
            mem_rdata = 32'hFFFF_FFFF;
            mem_ack   = 1'b1;
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== 32'h0 || mem_req !== 1'b0) begin
                errors++; $display("FAIL store%0d_done: valid %b err %b data %h req %b expected 1 0 0 0", i, out_valid, out_err, out_data, mem_req); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL store%0d_idle: valid %b ready %b expected 0 1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s   [7] = '{LB, LBU, LH, LHU, LW, LB, LW};
        logic [1:0]  areas [7] = '{AREA_B, AREA_B, AREA_H, AREA_H, AREA_W, AREA_B, AREA_W};
        logic [31:0] addrs [7] = '{32'h202, 32'h202, 32'h200, 32'h202, 32'h204, 32'h201, 32'h208};
        logic [31:0] rds   [7] = '{32'h12F45678, 32'h12F45678, 32'h00008001, 32'h80010000,
                                   32'hCAFEF00D, 32'h00007F00, 32'h0BADF00D};
        int          waits [7] = '{3, 3, 0, 0, 1, 2, 15};
        logic [31:0] e_data[7] = '{32'hFFFFFFF4, 32'h000000F4, 32'hFFFF8001, 32'h00008001,
                                   32'hCAFEF00D, 32'h0000007F, 32'h0BADF00D};
        logic [31:0] e_addr;
        for (int i = 0; i < 7; i++) begin
            e_addr = {addrs[i][31:2], 2'b00};
            drive_op(1'b0, areas[i], SEL_MEM, f3s[i], addrs[i], 32'h5555_5555, 32'h0);
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'b0000 || mem_addr !== e_addr) begin
                errors++; $display("FAIL load%0d_req: req %b we %b wstrb %b addr %h expected 1 0 0000 %h", i, mem_req, mem_we, mem_wstrb, mem_addr, e_addr); end
            for (int w = 0; w < waits[i]; w++) begin
                @(posedge clk); #1;
                checks++; if (in_ready !== 1'b0 || mem_req !== 1'b1 || out_valid !== 1'b0 || mem_addr !== e_addr) begin
                    errors++; $display("FAIL load%0d_wait%0d: ready %b req %b valid %b addr %h expected 0 1 0 %h", i, w, in_ready, mem_req, out_valid, mem_addr, e_addr); end
            end
            mem_rdata = rds[i];
            mem_ack   = 1'b1;
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            checks++; if (out_valid !== 1'b1 || out_err !== 1'b0) begin
                errors++; $display("FAIL load%0d_valid: valid %b err %b expected 1 0", i, out_valid, out_err); end
            checks++; if (out_data !== e_data[i]) begin errors++; $display("FAIL load%0d_data: got %h expected %h", i, out_data, e_data[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bad_access();
        logic        wes   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]  areas [4] = '{AREA_H, AREA_W, AREA_W, AREA_BAD};
        logic [1:0]  sels  [4] = '{SEL_MEM, SEL_MEM, SEL_ALU, SEL_ALU};
        logic [2:0]  f3s   [4] = '{LH, LW, 3'b010, 3'b011};
        logic [31:0] addrs [4] = '{32'h201, 32'h202, 32'h102, 32'h200};
        for (int i = 0; i < 4; i++) begin
            drive_op(wes[i], areas[i], sels[i], f3s[i], addrs[i], 32'hA5A5_A5A5, 32'h0);
            checks++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 32'h0) begin
                errors++; $display("FAIL bad%0d: req %b valid %b err %b data %h expected 0 1 1 0", i, mem_req, out_valid, out_err, out_data); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req !== 1'b0) begin
                errors++; $display("FAIL bad%0d_idle: valid %b ready %b req %b expected 0 1 0", i, out_valid, in_ready, mem_req); end
        end
    endtask

    task automatic test_passthru();
        drive_op(1'b0, AREA_W, SEL_PC4, 3'b000, 32'h55, 32'h0, 32'h84);
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== 32'h84 || mem_req !== 1'b0) begin
            errors++; $display("FAIL jal: valid %b err %b data %h req %b expected 1 0 00000084 0", out_valid, out_err, out_data, mem_req); end
        @(posedge clk); #1;
        drive_op(1'b0, AREA_BAD, SEL_ALU, 3'b000, 32'h7, 32'h0, 32'h84);
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_data !== 32'h7 || mem_req !== 1'b0) begin
            errors++; $display("FAIL alu_op: valid %b err %b data %h req %b expected 1 0 00000007 0", out_valid, out_err, out_data, mem_req); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL alu_idle: valid %b ready %b expected 0 1", out_valid, in_ready); end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int seen       = 0;
        drive_op(1'b0, AREA_W, SEL_MEM, LW, 32'h400, 32'h0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) begin
                seen = 1;
                break;
            end
            if (mem_req === 1'b1) req_cycles++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL timeout_bound: out_valid not seen within 40 cycles, expected within 17"); end
        checks++; if (req_cycles != 16) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 16", req_cycles); end
        checks++; if (out_err !== 1'b1 || out_data !== 32'h0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL timeout_done: err %b data %h req %b expected 1 0 0", out_err, out_data, mem_req); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        int stray = 0;
        drive_op(1'b0, AREA_W, SEL_MEM, LW, 32'h500, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (mem_req !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL rst_mid: req %b ready %b valid %b addr %h expected 0 1 0 0", mem_req, in_ready, out_valid, mem_addr); end
        mem_rdata = 32'h1234_5678;
        mem_ack   = 1'b1;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b0 || mem_req !== 1'b0) stray++;
            @(posedge clk); #1;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL late_ack: got %0d cycles with activity expected 0", stray); end
        checks++; if (out_data !== 32'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL late_ack_state: data %h ready %b expected 0 1", out_data, in_ready); end
    endtask

    initial begin
        in_valid   = 1'b0;
        memwrite   = 1'b0;
        memarea    = AREA_W;
        memsel     = SEL_ALU;
        funct3     = 3'b000;
        alu_res    = 32'h0;
        store_data = 32'h0;
        pc4        = 32'h0;
        mem_rdata  = 32'h0;
        mem_ack    = 1'b0;
        test_reset();
        test_stores();
        test_loads();
        test_bad_access();
        test_passthru();
        test_timeout();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
